// File: rtl/nec_ir_transmitter_pkg.sv
// Shared types and constants for the NEC IR transmitter.
package nec_ir_pkg;

   typedef enum logic [2:0] {
      StIdle        = 3'd0,
      StLeaderMark  = 3'd1,
      StLeaderSpace = 3'd2,
      StBitMark     = 3'd3,
      StBitSpace    = 3'd4,
      StStopMark    = 3'd5,
      StGap         = 3'd6
   } nec_tx_state_t;

   localparam int unsigned LEADER_MARK_UNITS  = 16;
   localparam int unsigned LEADER_SPACE_UNITS = 8;
   localparam int unsigned BIT_MARK_UNITS     = 1;
   localparam int unsigned ZERO_SPACE_UNITS   = 1;
   localparam int unsigned ONE_SPACE_UNITS    = 3;
   localparam int unsigned STOP_MARK_UNITS    = 1;
   localparam int unsigned GAP_UNITS          = 40;
   localparam int unsigned FRAME_BITS         = 32;

   // Wide enough for the longest state (GAP_UNITS)
   localparam int unsigned UNIT_W = 6;

   // Cycles per 562.5 us unit, truncated
   function automatic int unsigned nec_unit_cycles(input longint unsigned clock_hz);
      longint unsigned w_cycles;
      w_cycles = clock_hz * 64'd5625 / 64'd10_000_000;
      return 32'(w_cycles);
   endfunction

endpackage

// File: rtl/nec_ir_transmitter_if.sv
// Request/status bundle between a frame source and the NEC IR transmitter.
interface nec_ir_transmitter_if;
   logic        txStartIN;
   logic [31:0] dataIN;
   logic        busyOUT;
   logic        txDoneOUT;
   logic        txOUT;

   modport master (output txStartIN, dataIN, input busyOUT, txDoneOUT, txOUT);
   modport slave  (input txStartIN, dataIN, output busyOUT, txDoneOUT, txOUT);
endinterface

// File: rtl/nec_ir_transmitter_timer.sv
// Unit timer: counts i_units whole units of UNIT_CYCLES cycles and flags the last cycle.
module nec_unit_timer
   import nec_ir_pkg::*;
#(
   parameter int unsigned UNIT_CYCLES = 900
) (
   input  logic              clkIN,
   input  logic              resetIN,
   input  logic              i_restart,
   input  logic [UNIT_W-1:0] i_units,
   output logic              o_expire
);

   localparam int unsigned CW = $clog2(UNIT_CYCLES * 16 + 1);
   localparam logic [CW-1:0] CycLast = CW'(UNIT_CYCLES - 1);

   logic [CW-1:0]     r_cyc;
   logic [UNIT_W-1:0] r_unit;
   logic              w_unit_end;

   assign w_unit_end = (r_cyc == CycLast);
   // Restart is deliberately not folded in here: the caller derives restart from expire
   assign o_expire   = w_unit_end && ((r_unit + UNIT_W'(1)) == i_units);

   // Cycle-within-unit and unit counters, cleared whenever the caller changes state
   always_ff @(posedge clkIN or posedge resetIN) begin
      if (resetIN) begin
         r_cyc  <= '0;
         r_unit <= '0;
      end else if (i_restart) begin
         r_cyc  <= '0;
         r_unit <= '0;
      end else if (w_unit_end) begin
         r_cyc  <= '0;
         r_unit <= r_unit + UNIT_W'(1);
      end else begin
         r_cyc  <= r_cyc + CW'(1);
      end
   end

endmodule

// File: rtl/nec_ir_transmitter.sv
// NEC IR frame transmitter: leader, 32 pulse-distance bits MSB first, stop mark, gap.
// Optional carrier modulation of marks when NEC_IR_CARRIER_EN is defined.
module nec_ir_transmitter
   import nec_ir_pkg::*;
#(
   parameter int unsigned CLOCK_HZ   = 50_000_000,
   parameter int unsigned CARRIER_HZ = 38_000
) (
   input  logic           clkIN,
   input  logic           resetIN,
   nec_ir_transmitter_if.slave bus
);

   localparam int unsigned UNIT_CYCLES = nec_unit_cycles(64'(CLOCK_HZ));

   if (UNIT_CYCLES == 0 || CARRIER_HZ == 0) begin : g_param_check
      $error("nec_ir_transmitter: CLOCK_HZ too low or CARRIER_HZ zero");
   end

   nec_tx_state_t     r_state, w_state_next;
   logic [31:0]       r_shift;
   logic [5:0]        r_bit;
   logic              r_tx, r_busy, r_done;
   logic [UNIT_W-1:0] w_units;
   logic              w_expire, w_restart, w_mark, w_car_on;

   // Timer restarts on every state change and is held clear while idle
   assign w_restart = (r_state == StIdle) || w_expire;
   assign w_mark    = (r_state == StLeaderMark) || (r_state == StBitMark) ||
                      (r_state == StStopMark);

   nec_unit_timer #(
      .UNIT_CYCLES (UNIT_CYCLES)
   ) u_timer (
      .clkIN     (clkIN),
      .resetIN   (resetIN),
      .i_restart (w_restart),
      .i_units   (w_units),
      .o_expire  (w_expire)
   );

   // Next-state and per-state duration
   always_comb begin
      w_state_next = r_state;
      w_units      = '0;
      unique case (r_state)
         StIdle: begin
            if (bus.txStartIN) w_state_next = StLeaderMark;
         end
         StLeaderMark: begin
            w_units = UNIT_W'(LEADER_MARK_UNITS);
            if (w_expire) w_state_next = StLeaderSpace;
         end
         StLeaderSpace: begin
            w_units = UNIT_W'(LEADER_SPACE_UNITS);
            if (w_expire) w_state_next = StBitMark;
         end
         StBitMark: begin
            w_units = UNIT_W'(BIT_MARK_UNITS);
            if (w_expire) w_state_next = StBitSpace;
         end
         StBitSpace: begin
            w_units = r_shift[31] ? UNIT_W'(ONE_SPACE_UNITS) : UNIT_W'(ZERO_SPACE_UNITS);
            if (w_expire) begin
               w_state_next = (r_bit == 6'(FRAME_BITS - 1)) ? StStopMark : StBitMark;
            end
         end
         StStopMark: begin
            w_units = UNIT_W'(STOP_MARK_UNITS);
            if (w_expire) w_state_next = StGap;
         end
         StGap: begin
            w_units = UNIT_W'(GAP_UNITS);
            if (w_expire) w_state_next = StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   // State register
   always_ff @(posedge clkIN or posedge resetIN) begin
      if (resetIN) r_state <= StIdle;
      else         r_state <= w_state_next;
   end

   // Payload latch on accept; shift and count at the end of every bit space
   always_ff @(posedge clkIN or posedge resetIN) begin
      if (resetIN) begin
         r_shift <= '0;
         r_bit   <= '0;
      end else if ((r_state == StIdle) && bus.txStartIN) begin
         r_shift <= bus.dataIN;
         r_bit   <= '0;
      end else if ((r_state == StBitSpace) && w_expire) begin
         r_shift <= {r_shift[30:0], 1'b0};
         r_bit   <= r_bit + 6'd1;
      end
   end

`ifdef NEC_IR_CARRIER_EN
   localparam int unsigned CARRIER_CYCLES = CLOCK_HZ / CARRIER_HZ;
   localparam int unsigned CarW = $clog2(CARRIER_CYCLES + 1);

   logic [CarW-1:0] r_car;

   // Carrier phase counter; restarting with the timer puts a high phase at each mark start
   always_ff @(posedge clkIN or posedge resetIN) begin
      if (resetIN)                                   r_car <= '0;
      else if (w_restart)                            r_car <= '0;
      else if (r_car == CarW'(CARRIER_CYCLES - 1))   r_car <= '0;
      else                                           r_car <= r_car + CarW'(1);
   end

   assign w_car_on = (r_car < CarW'(CARRIER_CYCLES / 3));
`else
   assign w_car_on = 1'b1;
`endif

   // Registered outputs; done fires on the cycle busy falls
   always_ff @(posedge clkIN or posedge resetIN) begin
      if (resetIN) begin
         r_tx   <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_tx   <= w_mark && w_car_on;
         r_busy <= (r_state != StIdle);
         r_done <= r_busy && (r_state == StIdle);
      end
   end

   assign bus.txOUT     = r_tx;
   assign bus.busyOUT   = r_busy;
   assign bus.txDoneOUT = r_done;

endmodule

// File: doc/nec_ir_transmitter.md
# nec_ir_transmitter

Serialises a 32-bit word into an NEC infrared frame: leader burst, 32 pulse-distance-coded bits sent MSB first, a stop burst, then an enforced inter-frame gap. It is the transmit-side counterpart of NecIrReceiver. `txOUT` drives an IR LED driver, or loops back into NecIrReceiver for self-test. Bursts are active-high, which matches the demodulated envelope NecIrReceiver expects.

## Interface
- CLOCK_HZ, 50_000_000, system clock frequency in Hz
- CARRIER_HZ, 38_000, carrier frequency; used only when carrier is compiled in
- clkIN  input  1  system clock, rising edge
- resetIN  input  1  reset, asynchronous, active-high
- txStartIN  input  1  frame request; sampled only while idle
- dataIN  input  32  frame payload; bit 31 is sent first
- busyOUT  output  1  high from the cycle after an accepted start until the gap ends
- txDoneOUT  output  1  single-cycle pulse at frame completion
- txOUT  output  1  IR output; high = burst (mark), low = space

## Operation
- Unit time is 562.5 µs. UNIT_CYCLES = CLOCK_HZ*5625/10_000_000, computed with 64-bit localparam arithmetic and truncated. The counter width is $clog2(UNIT_CYCLES*16+1).
- States, with durations in units:
  - IDLE
  - LEADER_MARK: 16
  - LEADER_SPACE: 8
  - BIT_MARK: 1
  - BIT_SPACE: 1 for a 0, 3 for a 1
  - STOP_MARK: 1
  - GAP: 40
- Transitions:
  - IDLE -> LEADER_MARK when txStartIN=1. dataIN is latched into a shift register on that edge.
  - LEADER_SPACE -> BIT_MARK.
  - BIT_SPACE -> BIT_MARK while bits remain (6-bit bit counter, 0..31). After bit 31 it goes to STOP_MARK.
  - STOP_MARK -> GAP -> IDLE.
- The shift register shifts left at the end of each BIT_SPACE. The current bit is always reg[31].
- txOUT = 1 in mark states and 0 otherwise. It is registered.
- Frame length in units = 89 + 2·popcount(data). Total busy time is that plus 40.
- txStartIN while busy is ignored and not queued. dataIN changes while busy have no effect.
- Reset values: state IDLE, txOUT 0, busyOUT 0, txDoneOUT 0, all counters and the shift register 0. Reset asserted mid-frame aborts immediately; no partial frame resumes.

## Timing
- Start is accepted at edge N (IDLE, txStartIN=1). At edge N+1, busyOUT=1 and txOUT=1.
- Each state lasts exactly units·UNIT_CYCLES cycles. There is no drift across state boundaries: the unit counter restarts on every state change.
- On the final GAP cycle the block registers IDLE. At the next edge busyOUT=0 and txDoneOUT=1 for exactly one cycle.
- A start sampled in the same cycle that txDoneOUT is high is accepted, so frames can run back to back with only the 40-unit gap between them.

## Configuration
- NEC_IR_CARRIER_EN defined: during mark states, txOUT is a carrier of period CARRIER_CYCLES = CLOCK_HZ/CARRIER_HZ.
  - It is high for the first CARRIER_CYCLES/3 cycles of each period.
  - The carrier phase restarts at the first cycle of every mark.
  - Spaces remain constant 0.
- NEC_IR_CARRIER_EN undefined: txOUT is the plain envelope, and CARRIER_HZ is unused.

## Structure
- Package nec_ir_pkg holds:
  - the state enum type nec_tx_state_t;
  - localparams LEADER_MARK_UNITS=16, LEADER_SPACE_UNITS=8, BIT_MARK_UNITS=1, ZERO_SPACE_UNITS=1, ONE_SPACE_UNITS=3, STOP_MARK_UNITS=1, GAP_UNITS=40, FRAME_BITS=32;
  - a function returning UNIT_CYCLES from CLOCK_HZ.
- Sub-module nec_unit_timer:
  - inputs: loadable unit count and synchronous restart;
  - output: single-cycle expire pulse;
  - reset: asynchronous active-high.

## Test plan
All cases use CLOCK_HZ=1_600_000, so UNIT_CYCLES=900.
- Reset with no start: all outputs are 0 for 10_000 cycles. Assert resetIN mid-cycle: outputs are 0 immediately, without waiting for a clock edge.
- dataIN=32'h00FF00FF, start pulse:
  - txOUT is high for 14400 cycles, then low for 7200.
  - The first bit pattern is a 900-cycle mark then a 900-cycle space.
  - Ones are a 900-cycle mark then a 2700-cycle space.
  - The stop mark is 900 cycles.
  - txDoneOUT pulses 144900 cycles after busyOUT rises.
- Loopback into NecIrReceiver (CLOCK_SPEED=CLOCK_HZ) with dataIN=32'h12345678: the receiver raises rxReadyOUT with dataOUT=32'h12345678.
- Start pulses and dataIN toggling during the frame: the waveform is identical to the undisturbed frame. No second frame starts after txDoneOUT unless a new start arrives.
- resetIN pulse during the BIT_SPACE of bit 10:
  - txOUT and busyOUT are 0 at once.
  - No txDoneOUT pulse occurs.
  - A following start for 32'hA5A5A5A5 produces a complete, correctly timed frame.
- With NEC_IR_CARRIER_EN (CARRIER_HZ=38_000, CARRIER_CYCLES=42):
  - Leader mark toggles with period 42 cycles, high for 14.
  - The first cycle of every mark is high.
  - Spaces are constant 0.
